// File: rtl/core_pkg.sv
// Shared definitions for the single-cycle core: sequencer states, problem IDs,
// per-problem start addresses and default widths.
package core_pkg;

  localparam int unsigned PC_W_DEF   = 8;
  localparam int unsigned LOOP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] P_PROD = 2'd0;
  localparam logic [1:0] P_DIV  = 2'd1;
  localparam logic [1:0] P_PAT  = 2'd2;

  // Every problem has its own program image, so all programs start at 0.
  function automatic int unsigned start_addr(input logic [1:0] prob);
    int unsigned addr;
    case (prob)
      P_PROD:  addr = 0;
      P_DIV:   addr = 0;
      P_PAT:   addr = 0;
      default: addr = 0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/loop_counter.sv
// Hardware loop counter: load, guarded decrement, zero detect.
module loop_counter
  import core_pkg::*;
#(
  parameter int unsigned LOOP_W = LOOP_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [LOOP_W-1:0] i_init,
  input  logic              i_dec,
  output logic [LOOP_W-1:0] o_cnt,
  output logic              o_zero
);

  logic [LOOP_W-1:0] r_cnt;

  // Load wins over decrement; decrement is blocked at zero so it never underflows.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_init;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program-sequencing controller: owns the PC, run state and loop counter,
// drives the external branch-target LUT and performs the Start/Done handshake.
module pc_branch_ctrl
  import core_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned LOOP_W = LOOP_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        ProblemSel,
  input  logic              Halt,
  input  logic              BranchEn,
  input  logic              BranchCond,
  input  logic              LoopBr,
  input  logic              LoopLoad,
  input  logic [LOOP_W-1:0] LoopInit,
  input  logic [3:0]        JptrCon,
  input  logic [2:0]        JptrB,
  input  logic [PC_W-1:0]   JumpTgt,
  output logic [1:0]        LutProblem,
  output logic              LutLoopBranch,
  output logic [3:0]        LutJptrCon,
  output logic [2:0]        LutJptrB,
  output logic [PC_W-1:0]   ProgCtr,
  output logic [LOOP_W-1:0] LoopCnt,
  output logic              Busy,
  output logic              Done,
  output logic              Fault
);

  state_t            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [1:0]        r_prob, w_prob_nxt;
  logic              r_fault_pend, w_fault_nxt;
  logic              w_lc_load, w_lc_dec, w_lc_zero;
  logic [LOOP_W-1:0] w_lc_init;
  logic [PC_W-1:0]   w_start_pc;

  assign w_start_pc = PC_W'(start_addr(ProblemSel));

  loop_counter #(.LOOP_W(LOOP_W)) u_loop_counter (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_load (w_lc_load),
    .i_init (w_lc_init),
    .i_dec  (w_lc_dec),
    .o_cnt  (LoopCnt),
    .o_zero (w_lc_zero)
  );

  // State register; reset overrides any in-flight run.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_prob       <= '0;
      r_fault_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_prob       <= w_prob_nxt;
      r_fault_pend <= w_fault_nxt;
    end
  end

  // Next-state, next-PC and loop-counter control; JumpTgt is only selected
  // when a taken branch or loop branch fires.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_prob_nxt  = r_prob;
    w_fault_nxt = r_fault_pend;
    w_lc_load   = 1'b0;
    w_lc_init   = '0;
    w_lc_dec    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Start) begin
          if (ProblemSel != 2'd3) begin
            w_prob_nxt  = ProblemSel;
            w_pc_nxt    = w_start_pc;
            w_lc_load   = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_fault_nxt = 1'b1;
            w_state_nxt = FIN;
          end
        end
      end
      RUN: begin
        if (Halt) begin
          w_state_nxt = FIN;
        end else if (BranchEn && BranchCond) begin
          w_pc_nxt = JumpTgt;
        end else if (LoopBr && !BranchEn && !w_lc_zero) begin
          w_lc_dec = 1'b1;
          w_pc_nxt = JumpTgt;
        end else begin
          if (LoopLoad && !BranchEn && !LoopBr) begin
            w_lc_load = 1'b1;
            w_lc_init = LoopInit;
          end
          // Sequential advance: saturate at the top of memory and end the run.
          if (r_pc == '1) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = FIN;
          end else begin
            w_pc_nxt = r_pc + 1'b1;
          end
        end
      end
      FIN: begin
        w_fault_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign LutProblem    = r_prob;
  assign LutLoopBranch = LoopBr;
  assign LutJptrCon    = JptrCon;
  assign LutJptrB      = JptrB;
  assign ProgCtr       = r_pc;
  assign Busy          = (r_state == RUN);
  assign Done          = (r_state == FIN);
  assign Fault         = (r_state == FIN) && r_fault_pend;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the sequencing rules.
module tb_pc_branch_ctrl;

  localparam int unsigned PC_MAX = 255;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FIN  = 2;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, BranchEn, BranchCond, LoopBr, LoopLoad;
  logic [1:0] ProblemSel;
  logic [7:0] LoopInit, JumpTgt;
  logic [3:0] JptrCon;
  logic [2:0] JptrB;
  logic [1:0] LutProblem;
  logic       LutLoopBranch;
  logic [3:0] LutJptrCon;
  logic [2:0] LutJptrB;
  logic [7:0] ProgCtr, LoopCnt;
  logic       Busy, Done, Fault;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_st;
  int unsigned m_pc, m_cnt, m_prob;
  bit          m_fpend;

  pc_branch_ctrl #(.PC_W(8), .LOOP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProblemSel(ProblemSel),
    .Halt(Halt), .BranchEn(BranchEn), .BranchCond(BranchCond),
    .LoopBr(LoopBr), .LoopLoad(LoopLoad), .LoopInit(LoopInit),
    .JptrCon(JptrCon), .JptrB(JptrB), .JumpTgt(JumpTgt),
    .LutProblem(LutProblem), .LutLoopBranch(LutLoopBranch),
    .LutJptrCon(LutJptrCon), .LutJptrB(LutJptrB),
    .ProgCtr(ProgCtr), .LoopCnt(LoopCnt), .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // Reference behaviour: one clock of the sequencer, written from the rules.
  function automatic void model_step();
    bit advance;
    advance = 1'b0;
    if (Reset) begin
      m_st = M_IDLE; m_pc = 0; m_cnt = 0; m_prob = 0; m_fpend = 1'b0;
      return;
    end
    if (m_st == M_IDLE) begin
      if (Start) begin
        if (ProblemSel < 3) begin
          m_prob = ProblemSel; m_pc = 0; m_cnt = 0; m_st = M_RUN;
        end else begin
          m_st = M_FIN; m_fpend = 1'b1;
        end
      end
    end else if (m_st == M_RUN) begin
      if (Halt) m_st = M_FIN;
      else if (BranchEn) begin
        if (BranchCond) m_pc = JumpTgt;
        else advance = 1'b1;
      end else if (LoopBr) begin
        if (m_cnt != 0) begin m_cnt = m_cnt - 1; m_pc = JumpTgt; end
        else advance = 1'b1;
      end else begin
        if (LoopLoad) m_cnt = LoopInit;
        advance = 1'b1;
      end
      if (advance) begin
        if (m_pc == PC_MAX) begin m_st = M_FIN; m_fpend = 1'b1; end
        else m_pc = m_pc + 1;
      end
    end else begin
      m_st = M_IDLE; m_fpend = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    Reset = 0; Start = 0; ProblemSel = 0; Halt = 0; BranchEn = 0; BranchCond = 0;
    LoopBr = 0; LoopLoad = 0; LoopInit = 0; JptrCon = 0; JptrB = 0; JumpTgt = 0;
  endtask

  task automatic finish_run();
    Halt = 1; tick(); Halt = 0; tick();
  endtask

  task automatic test_reset();
    clear_inputs(); Reset = 1; tick(); tick(); Reset = 0;
    n_checks++; if (ProgCtr !== 8'd0 || LoopCnt !== 8'd0) begin n_fail++;
      $display("FAIL reset_init pc=%0d cnt=%0d required 0/0", ProgCtr, LoopCnt); end
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Fault !== 1'b0 || LutProblem !== 2'd0) begin n_fail++;
      $display("FAIL reset_flags busy=%b done=%b fault=%b prob=%0d required 0", Busy, Done, Fault, LutProblem); end
    Start = 1; ProblemSel = 2; tick(); Start = 0;
    LoopLoad = 1; LoopInit = 5; tick(); LoopLoad = 0;
    BranchEn = 1; BranchCond = 1; JumpTgt = 8'h12; tick(); BranchEn = 0; BranchCond = 0;
    n_checks++; if (ProgCtr !== 8'h12 || LoopCnt !== 8'd5 || Busy !== 1'b1) begin n_fail++;
      $display("FAIL reset_setup pc=%0h cnt=%0d busy=%b required 12/5/1", ProgCtr, LoopCnt, Busy); end
    Reset = 1; tick(); Reset = 0;
    n_checks++; if (ProgCtr !== 8'd0 || LoopCnt !== 8'd0 || Busy !== 1'b0 || Done !== 1'b0 || LutProblem !== 2'd0) begin n_fail++;
      $display("FAIL reset_midrun pc=%0h cnt=%0d busy=%b done=%b prob=%0d required all 0", ProgCtr, LoopCnt, Busy, Done, LutProblem); end
  endtask

  task automatic test_sequential();
    clear_inputs(); Start = 1; ProblemSel = 1; tick(); Start = 0;
    for (int i = 0; i <= 4; i++) begin
      n_checks++; if (ProgCtr !== 8'(i) || LutProblem !== 2'd1 || Busy !== 1'b1 || Done !== 1'b0) begin n_fail++;
        $display("FAIL seq_pc pc=%0d prob=%0d busy=%b done=%b required %0d/1/1/0", ProgCtr, LutProblem, Busy, Done, i); end
      if (i < 4) tick();
    end
    Halt = 1; tick(); Halt = 0;
    n_checks++; if (ProgCtr !== 8'd4 || Done !== 1'b1 || Fault !== 1'b0 || Busy !== 1'b0 || LutProblem !== 2'd1) begin n_fail++;
      $display("FAIL seq_halt pc=%0d done=%b fault=%b busy=%b required 4/1/0/0", ProgCtr, Done, Fault, Busy); end
    tick();
    n_checks++; if (ProgCtr !== 8'd4 || Done !== 1'b0) begin n_fail++;
      $display("FAIL seq_done_pulse pc=%0d done=%b required 4/0", ProgCtr, Done); end
  endtask

  task automatic test_branch();
    clear_inputs(); Start = 1; tick(); Start = 0;
    BranchEn = 1; BranchCond = 1; JumpTgt = 7; tick();
    JumpTgt = 123; tick();
    n_checks++; if (ProgCtr !== 8'd123) begin n_fail++;
      $display("FAIL branch_taken pc=%0d required 123", ProgCtr); end
    JumpTgt = 7; tick();
    BranchCond = 0; JumpTgt = 200; tick();
    n_checks++; if (ProgCtr !== 8'd8) begin n_fail++;
      $display("FAIL branch_not_taken pc=%0d required 8", ProgCtr); end
    BranchEn = 0; finish_run();
  endtask

  task automatic test_loop();
    clear_inputs(); Start = 1; tick(); Start = 0;
    LoopLoad = 1; LoopInit = 3; tick(); LoopLoad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      LoopBr = 1; JumpTgt = 11; tick(); LoopBr = 0;
      n_checks++;
      if (k < 3) begin
        if (ProgCtr !== 8'd11 || LoopCnt !== 8'(2 - k)) begin n_fail++;
          $display("FAIL loop_jump k=%0d pc=%0d cnt=%0d required 11/%0d", k, ProgCtr, LoopCnt, 2 - k); end
      end else begin
        if (ProgCtr !== 8'd13 || LoopCnt !== 8'd0) begin n_fail++;
          $display("FAIL loop_fallthrough pc=%0d cnt=%0d required 13/0", ProgCtr, LoopCnt); end
      end
    end
    finish_run();
  endtask

  task automatic test_priority();
    clear_inputs(); Start = 1; tick(); Start = 0;
    Halt = 1; BranchEn = 1; BranchCond = 1; JumpTgt = 99; tick(); clear_inputs();
    n_checks++; if (ProgCtr !== 8'd0 || Done !== 1'b1) begin n_fail++;
      $display("FAIL prio_halt pc=%0d done=%b required 0/1", ProgCtr, Done); end
    tick(); Start = 1; tick(); Start = 0;
    LoopLoad = 1; LoopInit = 2; tick();
    LoopBr = 1; LoopInit = 9; JumpTgt = 40; tick(); clear_inputs();
    n_checks++; if (ProgCtr !== 8'd40 || LoopCnt !== 8'd1) begin n_fail++;
      $display("FAIL prio_loopbr pc=%0d cnt=%0d required 40/1", ProgCtr, LoopCnt); end
    finish_run();
  endtask

  task automatic test_bad_problem();
    logic [7:0] pc_before;
    clear_inputs(); pc_before = ProgCtr;
    Start = 1; ProblemSel = 3; tick(); Start = 0; ProblemSel = 0;
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b1 || Fault !== 1'b1 || ProgCtr !== pc_before) begin n_fail++;
      $display("FAIL bad_problem busy=%b done=%b fault=%b pc=%0d required 0/1/1/%0d", Busy, Done, Fault, ProgCtr, pc_before); end
    tick();
    n_checks++; if (Done !== 1'b0 || Fault !== 1'b0) begin n_fail++;
      $display("FAIL bad_problem_pulse done=%b fault=%b required 0/0", Done, Fault); end
  endtask

  task automatic test_overflow();
    clear_inputs(); Start = 1; tick(); Start = 0;
    BranchEn = 1; BranchCond = 1; JumpTgt = 250; tick(); clear_inputs();
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (ProgCtr !== 8'd255 || Busy !== 1'b1) begin n_fail++;
      $display("FAIL ovf_reach pc=%0d busy=%b required 255/1", ProgCtr, Busy); end
    tick();
    n_checks++; if (ProgCtr !== 8'd255 || Done !== 1'b1 || Fault !== 1'b1) begin n_fail++;
      $display("FAIL ovf_fault pc=%0d done=%b fault=%b required 255/1/1", ProgCtr, Done, Fault); end
    tick();
    n_checks++; if (ProgCtr !== 8'd255 || Done !== 1'b0 || Busy !== 1'b0) begin n_fail++;
      $display("FAIL ovf_hold pc=%0d done=%b busy=%b required 255/0/0", ProgCtr, Done, Busy); end
  endtask

  task automatic test_back_to_back();
    clear_inputs(); Start = 1; ProblemSel = 2; tick();
    Halt = 1; tick(); Halt = 0;
    n_checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_fin done=%b busy=%b required 1/0", Done, Busy); end
    tick();
    n_checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle done=%b busy=%b required 0/0", Done, Busy); end
    tick();
    n_checks++; if (Busy !== 1'b1 || ProgCtr !== 8'd0 || LutProblem !== 2'd2) begin n_fail++;
      $display("FAIL b2b_restart busy=%b pc=%0d prob=%0d required 1/0/2", Busy, ProgCtr, LutProblem); end
    Start = 0; finish_run();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      Reset      = ($urandom_range(199) == 0);
      Start      = ($urandom_range(3) == 0);
      ProblemSel = 2'($urandom_range(3));
      Halt       = ($urandom_range(39) == 0);
      BranchEn   = ($urandom_range(5) == 0);
      BranchCond = 1'($urandom_range(1));
      LoopBr     = ($urandom_range(4) == 0);
      LoopLoad   = ($urandom_range(7) == 0);
      LoopInit   = 8'($urandom_range(6));
      JptrCon    = 4'($urandom_range(15));
      JptrB      = 3'($urandom_range(7));
      JumpTgt    = 8'($urandom_range(255));
      #1;
      n_checks++; if (LutLoopBranch !== LoopBr || LutJptrCon !== JptrCon || LutJptrB !== JptrB) begin n_fail++;
        $display("FAIL rand_passthru lb=%b jc=%0d jb=%0d required %b/%0d/%0d", LutLoopBranch, LutJptrCon, LutJptrB, LoopBr, JptrCon, JptrB); end
      tick();
      n_checks++;
      if (ProgCtr !== 8'(m_pc) || LoopCnt !== 8'(m_cnt) || LutProblem !== 2'(m_prob) ||
          Busy !== (m_st == M_RUN) || Done !== (m_st == M_FIN) || Fault !== (m_st == M_FIN && m_fpend)) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d pc=%0d cnt=%0d prob=%0d busy=%b done=%b fault=%b required %0d/%0d/%0d/%b/%b/%b",
                 c, ProgCtr, LoopCnt, LutProblem, Busy, Done, Fault, m_pc, m_cnt, m_prob,
                 m_st == M_RUN, m_st == M_FIN, m_st == M_FIN && m_fpend);
      end
    end
    clear_inputs();
  endtask

  initial begin
    m_st = M_IDLE; m_pc = 0; m_cnt = 0; m_prob = 0; m_fpend = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_loop();
    test_priority();
    test_bad_problem();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
Program-sequencing controller for the single-cycle core.
- Owns the program counter, the per-problem run state and a hardware loop counter.
- Drives the select/pointer inputs of the combinational branch-target LUT and consumes its 8-bit absolute jump target to form the next PC.
- Sits between the instruction decoder and instruction memory; handles the Start/Done handshake with the testbench/top level.

Parameters:
PC_W, 8, program counter width; instruction memory depth is 2**PC_W.
LOOP_W, 8, loop counter width.

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high
Start  in  1  run request; sampled only in IDLE
ProblemSel  in  2  program to run (0..2 valid); latched on accepted Start
Halt  in  1  decoded halt instruction at current PC
BranchEn  in  1  decoded conditional branch
BranchCond  in  1  ALU condition flag; branch taken when 1
LoopBr  in  1  decoded loop-branch instruction
LoopLoad  in  1  decoded load-loop-count instruction
LoopInit  in  LOOP_W  count value for LoopLoad
JptrCon  in  4  conditional-branch target index from instruction
JptrB  in  3  loop-branch target index from instruction
JumpTgt  in  PC_W  absolute target returned by branch LUT
LutProblem  out  2  latched problem register, to LUT
LutLoopBranch  out  1  equals LoopBr (combinational), to LUT
LutJptrCon  out  4  equals JptrCon (combinational)
LutJptrB  out  3  equals JptrB (combinational)
ProgCtr  out  PC_W  current instruction address
LoopCnt  out  LOOP_W  current loop count (debug/observability)
Busy  out  1  high in RUN
Done  out  1  one-cycle pulse on completion
Fault  out  1  one-cycle pulse, coincident with Done, on abnormal end

Behaviour:
- Reset (synchronous; overrides everything, including mid-run): state=IDLE, ProgCtr=0, LoopCnt=0, problem reg=0, Busy=0, Done=0, Fault=0.
- FSM states: IDLE, RUN, FIN.
- IDLE transitions:
  - Start && ProblemSel<3: latch ProblemSel; ProgCtr <= START_ADDR[ProblemSel]; LoopCnt <= 0; go RUN.
  - Start && ProblemSel==3: go FIN with fault pending; ProgCtr unchanged.
  - Otherwise hold all state.
- RUN: exactly one action per cycle, priority highest first:
  1. Halt: go FIN; ProgCtr holds.
  2. BranchEn && BranchCond: ProgCtr <= JumpTgt.
  3. BranchEn && !BranchCond: ProgCtr <= ProgCtr+1.
  4. LoopBr && LoopCnt!=0: LoopCnt <= LoopCnt-1; ProgCtr <= JumpTgt.
  5. LoopBr && LoopCnt==0: ProgCtr <= ProgCtr+1 (fall through). A loaded count N therefore takes the loop branch N times.
  6. LoopLoad: LoopCnt <= LoopInit; ProgCtr <= ProgCtr+1.
  7. Otherwise: ProgCtr <= ProgCtr+1.
- PC overflow: any increment with ProgCtr==2**PC_W-1 does not wrap; ProgCtr holds and the FSM goes FIN with fault pending.
- Branch latency: JumpTgt is used combinationally in the same cycle; the target address appears on ProgCtr the next cycle. There are no delay slots.
- LUT drive: LutProblem is registered (stable for the whole run); the other LUT outputs are pure pass-through. JumpTgt is ignored unless rule 2 or 4 fires, so X on unused LUT entries must not propagate into state.
- FIN: Done=1 for exactly one cycle, Fault=1 in the same cycle if a fault is pending; clear the pending flag; go IDLE. ProgCtr and LoopCnt hold so they remain readable.
- Start is ignored in RUN and FIN. A Start held high through FIN is accepted in the following IDLE cycle.
- Busy=1 exactly while in RUN.
- Counter arithmetic is unsigned. The LoopCnt decrement is guarded by !=0, so it never underflows.

Decomposition:
- Shared package (core_pkg): state enum {IDLE, RUN, FIN}; problem ID constants P_PROD=0, P_DIV=1, P_PAT=2; START_ADDR table, all entries 0 (each problem has its own program image); PC_W/LOOP_W defaults.
- The branch LUT stays a separate instance at core level and is not embedded here.
- One natural sub-module: loop_counter (load / decrement / zero-detect).

Test Plan:
1. Reset asserted in RUN with ProgCtr=0x12, LoopCnt=5 -> next cycle: IDLE, ProgCtr=0, LoopCnt=0, Busy=0, Done=0.
2. Start with ProblemSel=1, no branches for 4 cycles, then Halt -> ProgCtr 0,1,2,3,4 then holds 4; Done pulses exactly one cycle with Fault=0; LutProblem=1 throughout.
3. BranchEn=1, BranchCond=1, JumpTgt=123 at PC=7 -> PC=123 next cycle. Repeat with BranchCond=0 -> PC=8.
4. LoopLoad with LoopInit=3, then LoopBr every 2nd cycle with JumpTgt=11 -> three jumps to 11 (LoopCnt 3->2->1->0), fourth LoopBr falls through to PC+1.
5. Halt and BranchEn asserted together -> Halt wins, PC holds. LoopBr and LoopLoad together -> LoopBr action only, LoopCnt not loaded.
6. Start with ProblemSel=3 -> no RUN; Done and Fault both pulse one cycle. Separately, run to PC=255 without Halt -> Done+Fault, ProgCtr stays 255.
